// File: rtl/round_robin_pesado_tester_pkg.sv
// -----------------------------------------------------------------------------
// round_robin_pesado_tester_pkg
//
// Shared definitions for the weighted round-robin ("pesado") scheduler:
//   - rrp_weight_width(): weight field width, $clog2(MAX_WEIGHT)
//   - rrp_sel_width():    selector width, $clog2(QUEUE_QUANTITY) (min 1)
//   - rrp_next_eligible(): circular scan for the next eligible queue
//
// The scan helper works on a fixed-width eligibility vector
// (RRP_MAX_QUEUES bits) and takes the live queue count as an argument.
// Because of this, one function body serves any QUEUE_QUANTITY up to
// RRP_MAX_QUEUES.
// -----------------------------------------------------------------------------
package round_robin_pesado_tester_pkg;

  localparam int RRP_MAX_QUEUES = 32;
  localparam int RRP_IDX_BITS   = $clog2(RRP_MAX_QUEUES);

  // Result of a circular scan: valid is low when nothing is eligible.
  typedef struct packed {
    logic                    valid;
    logic [RRP_IDX_BITS-1:0] idx;
  } rrp_pick_t;

  function automatic int rrp_weight_width(input int max_weight);
    return (max_weight > 1) ? $clog2(max_weight) : 1;
  endfunction

  function automatic int rrp_sel_width(input int queues);
    return (queues > 1) ? $clog2(queues) : 1;
  endfunction

  // First eligible index among cur+1, cur+2, ... cur+n (mod n). cur itself
  // is visited last, so a lone eligible queue is still found.
  function automatic rrp_pick_t rrp_next_eligible(
    input logic [RRP_MAX_QUEUES-1:0] elig,
    input logic [RRP_IDX_BITS-1:0]   cur,
    input logic [RRP_IDX_BITS:0]     n
  );
    rrp_pick_t               pick;
    logic [RRP_IDX_BITS:0]   idx;
    logic [RRP_IDX_BITS:0]   step;
    pick = '0;
    for (int k = 1; k <= RRP_MAX_QUEUES; k++) begin
      step = (RRP_IDX_BITS + 1)'(k);
      if (step <= n) begin
        // cur < n and step <= n, so a single subtraction is a full modulo.
        idx = {1'b0, cur} + step;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!pick.valid && elig[idx[RRP_IDX_BITS-1:0]]) begin
          pick.valid = 1'b1;
          pick.idx   = idx[RRP_IDX_BITS-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/round_robin_pesado_tester_core.sv
// -----------------------------------------------------------------------------
// round_robin_pesado_core
//
// One weighted round-robin arbiter. The current queue keeps the grant until
// it has received weight[cur] consecutive grants, goes empty, or its weight
// drops to or below the grant count. When that happens the grant moves to the
// next eligible queue in circular order. A queue is eligible when it is
// non-empty and has a non-zero weight.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   enb          - arbitration enable; low means no grant and all state holds
//   pesos        - packed weights, queue i at [i*W +: W]
//   buf_empty    - bit i high means queue i is empty
//   selector     - registered granted queue index (holds when no grant)
//   selector_enb - registered grant valid
// -----------------------------------------------------------------------------
module round_robin_pesado_core
  import round_robin_pesado_tester_pkg::*;
#(
  parameter  int QUEUE_QUANTITY = 4,
  parameter  int MAX_WEIGHT     = 64,
  localparam int W              = rrp_weight_width(MAX_WEIGHT),
  localparam int SW             = rrp_sel_width(QUEUE_QUANTITY)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  input  logic [QUEUE_QUANTITY*W-1:0] pesos,
  input  logic [QUEUE_QUANTITY-1:0]   buf_empty,
  output logic [SW-1:0]               selector,
  output logic                        selector_enb
);

  logic [W-1:0]              weights [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] elig;
  logic [RRP_MAX_QUEUES-1:0] elig_pad;

  logic [SW-1:0] cur_reg, cur_next;
  logic [W-1:0]  cnt_reg, cnt_next;
  logic [SW-1:0] sel_reg, sel_next;
  logic          sel_enb_reg, sel_enb_next;

  logic [W-1:0]  weight_cur;
  logic          cur_elig;
  rrp_pick_t     pick;

  generate
    for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_queue
      assign weights[gi] = pesos[gi*W +: W];
      assign elig[gi]    = !buf_empty[gi] && (pesos[gi*W +: W] != '0);
    end
  endgenerate

  always_comb begin
    elig_pad                     = '0;
    elig_pad[QUEUE_QUANTITY-1:0] = elig;
  end

  assign weight_cur = weights[cur_reg];
  assign cur_elig   = elig[cur_reg];
  assign pick       = rrp_next_eligible(elig_pad, RRP_IDX_BITS'(cur_reg),
                                        (RRP_IDX_BITS + 1)'(QUEUE_QUANTITY));

  // Next-state decision. A weight lowered mid-burst takes effect here
  // immediately: cnt >= new weight fails the burst test and forces a move.
  always_comb begin
    cur_next     = cur_reg;
    cnt_next     = cnt_reg;
    sel_next     = sel_reg;
    sel_enb_next = 1'b0;
    if (enb) begin
      if (cur_elig && (cnt_reg < weight_cur)) begin
        // cnt < weight <= 2**W-1, so the increment cannot wrap.
        cnt_next     = cnt_reg + 1'b1;
        sel_next     = cur_reg;
        sel_enb_next = 1'b1;
      end else if (pick.valid) begin
        cur_next     = SW'(pick.idx);
        cnt_next     = W'(1);
        sel_next     = SW'(pick.idx);
        sel_enb_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg     <= '0;
      cnt_reg     <= '0;
      sel_reg     <= '0;
      sel_enb_reg <= 1'b0;
    end else begin
      cur_reg     <= cur_next;
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      sel_enb_reg <= sel_enb_next;
    end
  end

  assign selector     = sel_reg;
  assign selector_enb = sel_enb_reg;

endmodule

// File: rtl/round_robin_pesado_tester.sv
// -----------------------------------------------------------------------------
// round_robin_pesado_tester
//
// Lock-step weighted round-robin scheduler. Two identical
// round_robin_pesado_core instances see the same inputs. Index 0 drives the
// primary selector and index 1 drives the shadow (sint_*) selector. Both are
// exported so downstream logic can compare them cycle by cycle.
//
// Ports:
//   clk               - clock, rising edge
//   rst               - asynchronous active-low reset
//   enb               - block enable
//   pesos             - packed weights, queue i at [i*W +: W]
//   buf_empty         - per-queue empty flags (1 = empty)
//   selector          - primary granted queue
//   selector_enb      - primary grant valid
//   sint_selector     - shadow granted queue
//   sint_selector_enb - shadow grant valid
//   mismatch          - (RRP_MISMATCH_FLAG_EN only) sticky divergence flag
//
// Build option: define RRP_MISMATCH_FLAG_EN to add the mismatch output. It
// is a sticky register that sets one cycle after the two cores disagree, and
// only reset clears it.
//
// DATA_BITS and BUF_WIDTH exist so this block drops into existing queue
// plumbing unchanged. They do not affect arbitration.
// -----------------------------------------------------------------------------
module round_robin_pesado_tester
  import round_robin_pesado_tester_pkg::*;
#(
  parameter  int QUEUE_QUANTITY = 4,
  parameter  int DATA_BITS      = 8,
  parameter  int MAX_WEIGHT     = 64,
  parameter  int BUF_WIDTH      = 3,
  localparam int W              = rrp_weight_width(MAX_WEIGHT),
  localparam int SW             = rrp_sel_width(QUEUE_QUANTITY)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  input  logic [QUEUE_QUANTITY*W-1:0] pesos,
  input  logic [QUEUE_QUANTITY-1:0]   buf_empty,
  output logic [SW-1:0]               selector,
  output logic                        selector_enb,
  output logic [SW-1:0]               sint_selector,
`ifdef RRP_MISMATCH_FLAG_EN
  output logic                        sint_selector_enb,
  output logic                        mismatch
`else
  output logic                        sint_selector_enb
`endif
);

  localparam int N_CORES = 2;

  logic [SW-1:0] core_sel     [N_CORES];
  logic          core_sel_enb [N_CORES];

  // Configurations outside the supported range produce no extra hardware.
  // The condition also records which parameters this wrapper relies on.
  generate
    if (QUEUE_QUANTITY > RRP_MAX_QUEUES || DATA_BITS < 1 || BUF_WIDTH < 1)
    begin : g_cfg_unsupported
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      round_robin_pesado_core #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .MAX_WEIGHT     (MAX_WEIGHT)
      ) u_core (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .selector     (core_sel[gi]),
        .selector_enb (core_sel_enb[gi])
      );
    end
  endgenerate

  assign selector          = core_sel[0];
  assign selector_enb      = core_sel_enb[0];
  assign sint_selector     = core_sel[1];
  assign sint_selector_enb = core_sel_enb[1];

`ifdef RRP_MISMATCH_FLAG_EN
  logic mismatch_reg;
  logic diverge;

  // Selectors are only compared while both grants are valid. With no grant
  // the held selector value carries no meaning.
  assign diverge = (core_sel_enb[0] != core_sel_enb[1]) ||
                   (core_sel_enb[0] && core_sel_enb[1] &&
                    (core_sel[0] != core_sel[1]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_reg <= 1'b0;
    end else if (diverge) begin
      mismatch_reg <= 1'b1;
    end
  end

  assign mismatch = mismatch_reg;
`endif

endmodule

// File: tb/tb_round_robin_pesado_tester.sv
// Directed + randomized bench for round_robin_pesado_tester. A queue-level
// reference (current queue, grants used in the burst) predicts each grant.
module tb_round_robin_pesado_tester;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic [N*W-1:0]  pesos;
  logic [N-1:0]    buf_empty;
  logic [SW-1:0]   selector, sint_selector;
  logic            selector_enb, sint_selector_enb;
`ifdef RRP_MISMATCH_FLAG_EN
  logic            mismatch;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  int m_cur, m_cnt, m_sel, m_en;

  int exp_seq [12] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3};

  always #5 clk = ~clk;

  round_robin_pesado_tester #(
    .QUEUE_QUANTITY (N),
    .DATA_BITS      (8),
    .MAX_WEIGHT     (64),
    .BUF_WIDTH      (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enb               (enb),
    .pesos             (pesos),
    .buf_empty         (buf_empty),
    .selector          (selector),
    .selector_enb      (selector_enb),
    .sint_selector     (sint_selector),
`ifdef RRP_MISMATCH_FLAG_EN
    .sint_selector_enb (sint_selector_enb),
    .mismatch          (mismatch)
`else
    .sint_selector_enb (sint_selector_enb)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int weight_of(input logic [N*W-1:0] p, input int q);
    return int'(p[q*W +: W]);
  endfunction

  function automatic bit is_elig(input logic [N*W-1:0] p, input logic [N-1:0] e, input int q);
    return (e[q] == 1'b0) && (weight_of(p, q) != 0);
  endfunction

  // Applies the scheduling rules to the inputs sampled at one edge.
  task automatic model_edge();
    bit found;
    if (!rst) begin
      m_cur = 0; m_cnt = 0; m_sel = 0; m_en = 0;
      return;
    end
    m_en = 0;
    if (!enb) return;
    if (is_elig(pesos, buf_empty, m_cur) && m_cnt < weight_of(pesos, m_cur)) begin
      m_cnt++;
      m_sel = m_cur;
      m_en  = 1;
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && is_elig(pesos, buf_empty, (m_cur + k) % N)) begin
          found = 1;
          m_cur = (m_cur + k) % N;
        end
      end
      if (found) begin
        m_cnt = 1;
        m_sel = m_cur;
        m_en  = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sel"},      32'(selector),          32'(m_sel));
    chk({tag, ".sel_enb"},  32'(selector_enb),      32'(m_en));
    chk({tag, ".sint"},     32'(sint_selector),     32'(m_sel));
    chk({tag, ".sint_enb"}, 32'(sint_selector_enb), 32'(m_en));
`ifdef RRP_MISMATCH_FLAG_EN
    chk({tag, ".mismatch"}, 32'(mismatch), 32'd0);
`endif
  endtask

  // One clock: inputs were set away from the edge; sample #1 after it.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    $display("cyc t=%0t rst=%0b enb=%0b empty=%b sel=%0d en=%0b sint=%0d sint_en=%0b",
             $time, rst, enb, buf_empty, selector, selector_enb, sint_selector, sint_selector_enb);
  endtask

  initial begin
    int prev_sel;
    bit reached;
    logic [N*W-1:0] base_pesos;

    // Weights queue0..3 = 1,2,3,6
    base_pesos = {6'd6, 6'd3, 6'd2, 6'd1};
    rst = 1'b0; enb = 1'b1; buf_empty = 4'b0000; pesos = base_pesos;
    m_cur = 0; m_cnt = 0; m_sel = 0; m_en = 0;
    #2;

    // Reset hold
    for (int i = 0; i < 3; i++) begin
      cycle("reset_hold");
      chk("reset_sel_zero", 32'(selector), 32'd0);
      chk("reset_enb_zero", 32'(selector_enb), 32'd0);
    end

    // Steady weighted service: two full periods against the literal sequence
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle("steady");
      chk("steady_seq", 32'(selector), 32'(exp_seq[i % 12]));
      chk("steady_enb", 32'(selector_enb), 32'd1);
    end

    // Partial empty: grants 0 then 1, then 0011 pulse forces queue 2
    cycle("pe_pre0");
    cycle("pe_pre1");
    chk("pe_at_q1", 32'(selector), 32'd1);
    buf_empty = 4'b0011;
    cycle("pe_pulse");
    chk("pe_goes_q2", 32'(selector), 32'd2);
    buf_empty = 4'b0000;
    for (int i = 0; i < 6; i++) cycle("pe_after");

    // All empty pulse
    prev_sel  = int'(selector);
    buf_empty = 4'b1111;
    cycle("ae_pulse");
    chk("ae_enb_low", 32'(selector_enb), 32'd0);
    chk("ae_sel_hold", 32'(selector), 32'(prev_sel));
    buf_empty = 4'b0000;
    for (int i = 0; i < 4; i++) cycle("ae_after");

    // Burst interruption on queue 3, then on queue 2
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_cur == 3 && m_cnt == 2) reached = 1; else cycle("bi_seek3");
    end
    chk("bi_reached3", 32'(reached), 32'd1);
    buf_empty = 4'b1000;
    cycle("bi_cut3");
    chk("bi_next_q0", 32'(selector), 32'd0);
    buf_empty = 4'b0000;
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_cur == 2 && m_cnt == 1) reached = 1; else cycle("bi_seek2");
    end
    chk("bi_reached2", 32'(reached), 32'd1);
    buf_empty = 4'b0100;
    cycle("bi_cut2");
    chk("bi_skip_q3", 32'(selector), 32'd3);
    buf_empty = 4'b0000;
    for (int i = 0; i < 3; i++) cycle("bi_after");

    // enb low for three cycles, then resume
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("enb_off");
      chk("enb_off_low", 32'(selector_enb), 32'd0);
    end
    enb = 1'b1;
    for (int i = 0; i < 12; i++) cycle("enb_resume");

    // Zero weight on queue 1: it must never be granted
    pesos = {6'd6, 6'd3, 6'd0, 6'd1};
    for (int i = 0; i < 20; i++) begin
      cycle("zero_w");
      chk("zero_w_no_q1", 32'(selector_enb && selector == 2'd1), 32'd0);
    end

    // Asynchronous reset between edges takes effect immediately
    #3;
    rst = 1'b0;
    #1;
    m_cur = 0; m_cnt = 0; m_sel = 0; m_en = 0;
    chk("async_rst_sel", 32'(selector), 32'd0);
    chk("async_rst_enb", 32'(selector_enb), 32'd0);
    chk("async_rst_sint_enb", 32'(sint_selector_enb), 32'd0);
    cycle("rst_low");
    rst   = 1'b1;
    pesos = base_pesos;
    for (int i = 0; i < 12; i++) begin
      cycle("post_rst");
      chk("post_rst_seq", 32'(selector), 32'(exp_seq[i]));
    end

    // Randomized phase: weights (including 0), empties, enable
    for (int i = 0; i < 400; i++) begin
      enb = ($urandom_range(0, 9) != 0);
      buf_empty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) buf_empty = 4'b0000;
      if ($urandom_range(0, 15) == 0) begin
        for (int q = 0; q < N; q++)
          pesos[q*W +: W] = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 7));
      end
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_robin_pesado_tester.md
Name: round_robin_pesado_tester

Overview:
- Weighted round-robin ("pesado") scheduling block with lock-step redundancy.
- Contains two identical instances of a weighted round-robin arbiter core, fed with the same inputs. One is the primary; the other is the shadow/synthesised-equivalent copy.
- Both selector outputs go out side by side, so downstream queue muxing and equivalence checking can compare them cycle by cycle.
- Sits between the per-queue buffers (via their empty flags) and the output multiplexer.

Parameters:
- QUEUE_QUANTITY, 4: number of queues arbitrated; selector width is $clog2(QUEUE_QUANTITY).
- DATA_BITS, 8: queue data width. Kept for interface compatibility; has no functional effect.
- MAX_WEIGHT, 64: weight range. Weight field width W = $clog2(MAX_WEIGHT) = 6.
- BUF_WIDTH, 3: buffer address width. Kept for interface compatibility; has no functional effect.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enb, input, 1: block enable.
- pesos, input, QUEUE_QUANTITY*W: weight of queue i is pesos[i*W +: W].
- buf_empty, input, QUEUE_QUANTITY: bit i high means queue i is empty.
- selector, output, $clog2(QUEUE_QUANTITY): queue granted by the primary core.
- selector_enb, output, 1: primary grant valid.
- sint_selector, output, $clog2(QUEUE_QUANTITY): queue granted by the shadow core.
- sint_selector_enb, output, 1: shadow grant valid.

Behaviour:
- Each core holds state registers cur (queue index) and cnt (W bits, grants given to cur in the current burst). Outputs are registered.
- Reset (rst low, asynchronous): cur=0, cnt=0, selector=0, selector_enb=0. The same applies to the sint_* outputs. Recovery from reset is synchronous to the next rising edge.
- Eligibility: queue i is eligible when buf_empty[i]==0 and its weight is not 0. Zero-weight queues are never granted.
- Each rising edge with enb=1 computes a candidate g:
  - Continue burst: g=cur, if cur is eligible and cnt < weight[cur]. Then cnt <= cnt+1.
  - Otherwise advance: g is the first eligible index scanning cur+1, cur+2, … cur+QUEUE_QUANTITY, modulo QUEUE_QUANTITY (cur itself is checked last). Then cnt <= 1.
  - Result: selector <= g, selector_enb <= 1, cur <= g.
- No eligible queue: selector_enb <= 0; selector, cur and cnt hold.
- enb=0: selector_enb <= 0; all other state holds. Arbitration resumes where it left off when enb returns high.
- Latency: buf_empty and pesos are sampled at edge k; the resulting grant is visible after edge k.
- Burst cut short: if cur becomes empty mid-burst, the next edge advances to the next eligible queue and cnt restarts at 1.
- Wrap-around with a single eligible queue: that queue is re-granted every cycle; cnt resets to 1 after each weight-length burst.
- Weights may change at any time. The new weight takes effect at the next comparison, so if cnt ≥ the new weight the block advances immediately.
- The primary and shadow cores are functionally identical. For identical inputs, sint_selector/sint_selector_enb equal selector/selector_enb on every cycle, including after reset.

Optional Feature:
- Macro: RRP_MISMATCH_FLAG_EN.
- When defined: adds output port mismatch (1 bit). It is registered and sticky. It sets one cycle after any cycle where selector_enb != sint_selector_enb, or where both are 1 and selector != sint_selector. It clears only on reset, to 0.
- When undefined: no port and no logic.

Decomposition:
- Shared package holds:
  - the weight width function/constant W = $clog2(MAX_WEIGHT);
  - the selector width constant;
  - a helper function that returns the next eligible index after a given index, scanning circularly.
- One natural sub-module, round_robin_pesado_core: the single weighted arbiter. It is instantiated twice (primary and shadow); the top level adds only wiring and the optional mismatch register.

Test Plan:
- Reset hold: rst low, enb=1, buf_empty=0000, pesos={6,3,2,1} → selector=0, selector_enb=0 on both cores throughout.
- Steady weighted service: release reset, all queues non-empty → grant sequence 0,1,1,2,2,2,3,3,3,3,3,3, repeating with period 12. selector_enb=1 and sint_* identical every cycle.
- Partial empty: during a grant of queue 1, pulse buf_empty=0011 for one cycle → that cycle's grant goes to queue 2 with cnt=1, then resumes the normal sequence. Queues 0 and 1 are not granted while empty.
- All empty: one-cycle pulse of buf_empty=1111 → selector_enb=0 for exactly one cycle, selector holds. Afterwards arbitration continues from the held cur.
- Burst interruption: buf_empty[3]=1 mid-burst on queue 3 → next grant is 0. Then buf_empty[2]=1 while at queue 2 → skip to 3.
- enb and zero weight: enb=0 for 3 cycles → selector_enb=0, sequence resumes unchanged. Setting pesos for queue 1 to 0 → queue 1 never granted, sequence 0,2,2,2,3×6.
